// File: rtl/button_event_gen.sv
// button_event_gen: turns the debounced button level into press, release,
//   long-press and auto-repeat single-cycle events, plus a held level and a
//   wrapping press count.
// Ports:
//   clk              - system clock, rising edge
//   reset            - asynchronous active-high reset
//   button_debounced - clean level from the debouncer (already synchronous to clk)
//   press_pulse      - 1 cycle after the sample that sees a 0->1 transition
//   release_pulse    - 1 cycle after the sample that sees low while a press is active
//   long_press       - 1 cycle after the LONG_CYCLES-th consecutive high sample
//   repeat_pulse     - every REPEAT_CYCLES high samples after long_press
//   held             - high while a recognised press is active
//   press_count      - number of press_pulse events, wraps at 256
// All outputs are registered; each event appears one cycle after its sampling edge.
module button_event_gen #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_debounced,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             prev;
    logic             press_nxt;
    logic             release_nxt;
    logic             long_nxt;
    logic             repeat_nxt;
    logic             held_nxt;
    logic [7:0]       count_nxt;

    assign cnt_inc = cnt + CNT_W'(1);

    // prev resets to 1 so a button held through reset is not taken as a
    // fresh press; it has to be seen low once before it can arm.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            prev          <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            prev          <= button_debounced;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_press    <= long_nxt;
            repeat_pulse  <= repeat_nxt;
            held          <= held_nxt;
            press_count   <= count_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        held_nxt    = held;
        count_nxt   = press_count;
        case (state)
            IDLE: begin
                if (button_debounced && !prev) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = CNT_W'(1);
                    press_nxt = 1'b1;
                    held_nxt  = 1'b1;
                    count_nxt = press_count + 8'd1;
                end
            end
            PRESSED: begin
                if (!button_debounced) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                    held_nxt    = 1'b0;
                end else if (cnt_inc == LONG_LAST) begin
                    // cnt holds the number of high samples seen so far,
                    // so this edge is sample #LONG_CYCLES.
                    state_nxt = LONG;
                    cnt_nxt   = '0;
                    long_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            LONG: begin
                if (!button_debounced) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                    held_nxt    = 1'b0;
                end else if (cnt_inc == REP_LAST) begin
                    cnt_nxt    = '0;
                    repeat_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                held_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: directed scenarios followed by randomized level runs,
//   every cycle compared against an event model derived from held-sample counts.
// Ports: none (drives clk, reset, button_debounced into button_event_gen).
module tb_button_event_gen;

    localparam int L = 8;
    localparam int R = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       button_debounced = 1'b0;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] press_count;

    button_event_gen #(
        .LONG_CYCLES  (L),
        .REPEAT_CYCLES(R),
        .CNT_W        (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .button_debounced(button_debounced),
        .press_pulse     (press_pulse),
        .release_pulse   (release_pulse),
        .long_press      (long_press),
        .repeat_pulse    (repeat_pulse),
        .held            (held),
        .press_count     (press_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a press is active from a low->high sample until the
    // first low sample; n is the number of high samples in that press.
    bit m_active = 1'b0;
    bit m_prev   = 1'b1;
    int m_n      = 0;
    int m_count  = 0;

    int seen_press = 0;
    int seen_release = 0;
    int seen_long = 0;
    int seen_repeat = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_prev   = 1'b1;
        m_n      = 0;
        m_count  = 0;
    endtask

    // One sample: drive the level, let the edge happen, check one cycle later.
    task automatic step(input bit b);
        bit e_press, e_rel, e_long, e_rep;
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0;
        if (!m_active) begin
            if (b && !m_prev) begin
                m_active = 1'b1;
                m_n      = 1;
                e_press  = 1'b1;
                m_count  = (m_count + 1) % 256;
            end
        end else if (b) begin
            m_n++;
            if (m_n == L) e_long = 1'b1;
            else if (m_n > L && ((m_n - L) % R) == 0) e_rep = 1'b1;
        end else begin
            e_rel    = 1'b1;
            m_active = 1'b0;
        end
        m_prev = b;

        button_debounced = b;
        @(posedge clk);
        #1;
        check("press_pulse",   {7'd0, press_pulse},   {7'd0, e_press});
        check("release_pulse", {7'd0, release_pulse}, {7'd0, e_rel});
        check("long_press",    {7'd0, long_press},    {7'd0, e_long});
        check("repeat_pulse",  {7'd0, repeat_pulse},  {7'd0, e_rep});
        check("held",          {7'd0, held},          {7'd0, m_active});
        check("press_count",   press_count,           8'(m_count));
        check("exclusive",     {7'd0, $onehot0({press_pulse, release_pulse, long_press, repeat_pulse})}, 8'd1);
        seen_press   += int'(press_pulse);
        seen_release += int'(release_pulse);
        seen_long    += int'(long_press);
        seen_repeat  += int'(repeat_pulse);
    endtask

    task automatic steps(input bit b, input int k);
        for (int i = 0; i < k; i++) step(b);
    endtask

    // Assert reset away from the clock edge, confirm outputs drop without
    // waiting for an edge, then hold it across one edge.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        check("rst_pulses", {4'd0, press_pulse, release_pulse, long_press, repeat_pulse}, 8'd0);
        check("rst_held", {7'd0, held}, 8'd0);
        check("rst_count", press_count, 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic clear_seen();
        seen_press = 0; seen_release = 0; seen_long = 0; seen_repeat = 0;
    endtask

    initial begin
        // Power-on reset.
        @(posedge clk);
        #1;
        do_reset();
        steps(1'b0, 2);

        // Short press: 3 high samples.
        clear_seen();
        steps(1'b1, 3);
        steps(1'b0, 2);
        check("short_press_n", 8'(seen_press), 8'd1);
        check("short_release_n", 8'(seen_release), 8'd1);
        check("short_long_n", 8'(seen_long), 8'd0);
        check("short_count", press_count, 8'd1);

        // Long hold: 20 high samples -> long at #8, repeats at #12/#16/#20.
        clear_seen();
        steps(1'b1, 20);
        steps(1'b0, 2);
        check("hold_long_n", 8'(seen_long), 8'd1);
        check("hold_repeat_n", 8'(seen_repeat), 8'd3);
        check("hold_release_n", 8'(seen_release), 8'd1);

        // Boundary: 7 samples gives no long press, 8 samples gives one.
        clear_seen();
        steps(1'b1, 7);
        step(1'b0);
        check("b7_long_n", 8'(seen_long), 8'd0);
        clear_seen();
        steps(1'b1, 8);
        check("b8_long_n", 8'(seen_long), 8'd1);
        step(1'b0);
        check("b8_release", {7'd0, release_pulse}, 8'd1);

        // Held through reset: ignored until seen low.
        button_debounced = 1'b1;
        do_reset();
        clear_seen();
        steps(1'b1, 4);
        check("stuck_press_n", 8'(seen_press), 8'd0);
        step(1'b0);
        step(1'b1);
        check("stuck_repress", {7'd0, press_pulse}, 8'd1);
        check("stuck_count", press_count, 8'd1);
        steps(1'b0, 2);

        // Reset in the LONG state after sample #10.
        steps(1'b1, 10);
        do_reset();
        clear_seen();
        steps(1'b1, 6);
        check("midlong_events", 8'(seen_press + seen_release + seen_long + seen_repeat), 8'd0);
        steps(1'b0, 2);

        // 256 short presses separated by 1-cycle lows.
        clear_seen();
        for (int i = 0; i < 256; i++) begin
            step(1'b1);
            step(1'b0);
        end
        check("wrap_count", press_count, 8'd0);
        check("wrap_press_lo", 8'(seen_press), 8'd0);
        check("wrap_press_hi", 8'(seen_press >> 8), 8'd1);
        check("wrap_rel_lo", 8'(seen_release), 8'd0);
        check("wrap_rel_hi", 8'(seen_release >> 8), 8'd1);

        // Randomized level runs with occasional resets.
        begin
            bit lvl;
            lvl = 1'b0;
            for (int r = 0; r < 150; r++) begin
                lvl = ~lvl;
                if ($urandom_range(0, 19) == 0) do_reset();
                steps(lvl, int'($urandom_range(1, 22)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
